// File: rtl/f_pc_ctrl.sv
// Fetch program-counter controller: boot sequencing, exception entry/return,
// branch redirect with a one-deep buffer held across stalls, and fetch address checking.
module f_pc_ctrl #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(32'h0000_6FFC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             fetch_exc,
  output logic             redir_pending
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  // Next-state: BOOT pins the PC for one cycle, RUN applies the flow-change priority.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    unique case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_d       = RESET_VEC;
        pc_valid_d = 1'b1;
        pend_d     = 1'b0;
      end
      RUN: begin
        pc_valid_d = 1'b1;
        if (req) begin
          pc_d   = EXC_VEC;
          pend_d = 1'b0;
        end else if (eret) begin
          pc_d   = epc;
          pend_d = 1'b0;
        end else if (redirect && stall) begin
          // Newest stalled redirect replaces any older buffered target.
          buf_d  = redirect_target;
          pend_d = 1'b1;
        end else if (redirect) begin
          pc_d   = redirect_target;
          pend_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pend_q) begin
          pc_d   = buf_q;
          pend_d = 1'b0;
        end else begin
          pc_d = pc_q + STEP_W;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign redir_pending = pend_q;

  // Address error flag only; it never changes sequencing by itself.
  assign fetch_exc = pc_valid_q &
                     ((pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI));

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Bench for f_pc_ctrl: directed scenarios followed by random traffic,
// all checked against a rule-level reference model.
module tb_f_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret, redirect;
  logic [31:0] epc, redirect_target;
  logic [31:0] pc;
  logic        pc_valid, fetch_exc, redir_pending;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_valid, m_pend;
  logic [31:0] m_buf;

  f_pc_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .req             (req),
    .eret            (eret),
    .epc             (epc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .fetch_exc       (fetch_exc),
    .redir_pending   (redir_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fe();
    return m_valid && ((m_pc % 4) != 0 || m_pc < 32'h0000_3000 || m_pc > 32'h0000_6FFC);
  endfunction

  task automatic set_in(input bit rs, input bit st, input bit rq, input bit er,
                        input logic [31:0] ep, input bit rd, input logic [31:0] tg);
    reset = rs; stall = st; req = rq; eret = er; epc = ep; redirect = rd; redirect_target = tg;
  endtask

  // Apply the spec's rules for one edge to the model.
  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h0000_3000; m_valid = 0; m_pend = 0; m_buf = 0;
    end else if (!m_valid) begin
      m_valid = 1; m_pc = 32'h0000_3000;
    end else if (req) begin
      m_pc = 32'h0000_4180; m_pend = 0;
    end else if (eret) begin
      m_pc = epc; m_pend = 0;
    end else if (redirect && stall) begin
      m_buf = redirect_target; m_pend = 1;
    end else if (redirect) begin
      m_pc = redirect_target; m_pend = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_pend) begin
      m_pc = m_buf; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".valid"}, 32'(pc_valid), 32'(m_valid));
    chk({tag, ".pend"}, 32'(redir_pending), 32'(m_pend));
    chk({tag, ".fexc"}, 32'(fetch_exc), 32'(model_fe()));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_valid = 0; m_pend = 0; m_buf = 0;
    set_in(1, 0, 0, 0, 0, 0, 0);

    // reset for two cycles, then boot sequence
    tick("rst0");
    set_in(1, 1, 1, 1, 32'h1234, 1, 32'h5678);
    tick("rst1");
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("boot");
    chk("boot_pc", pc, 32'h0000_3000);
    chk("boot_valid", 32'(pc_valid), 32'd1);
    tick("seq1");
    chk("seq1_pc", pc, 32'h0000_3004);
    tick("seq2");
    chk("seq2_pc", pc, 32'h0000_3008);
    tick("seq3");
    tick("seq4");
    chk("at3010", pc, 32'h0000_3010);

    // stalled redirect held for three cycles
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_3400);
    tick("stl_rd");
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick("stl2");
    tick("stl3");
    chk("stl_hold_pc", pc, 32'h0000_3010);
    chk("stl_pend", 32'(redir_pending), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("release");
    chk("release_pc", pc, 32'h0000_3400);
    chk("release_pend", 32'(redir_pending), 32'd0);

    // newest stalled redirect wins
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_3400);
    tick("ovw1");
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_3800);
    tick("ovw2");
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("ovw_rel");
    chk("ovw_pc", pc, 32'h0000_3800);

    // everything asserted together while a redirect is pending
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_3020);
    tick("to3020");
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_3500);
    tick("pend_pre");
    set_in(0, 1, 1, 1, 32'h0000_3024, 1, 32'h0000_3600);
    tick("allhot");
    chk("exc_pc", pc, 32'h0000_4180);
    chk("exc_pend", 32'(redir_pending), 32'd0);
    set_in(0, 1, 0, 1, 32'h0000_3024, 0, 0);
    tick("eret");
    chk("eret_pc", pc, 32'h0000_3024);

    // fetch address errors do not alter sequencing
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_3002);
    tick("unal");
    chk("unal_fexc", 32'(fetch_exc), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("unal_seq");
    chk("unal_seq_pc", pc, 32'h0000_3006);
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_7000);
    tick("hi");
    chk("hi_fexc", 32'(fetch_exc), 32'd1);
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_2FFC);
    tick("lo");
    chk("lo_fexc", 32'(fetch_exc), 32'd1);
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_6FFC);
    tick("top_ok");
    chk("top_fexc", 32'(fetch_exc), 32'd0);

    // wrap from the top of the address space
    set_in(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick("wrap0");
    chk("wrap0_fexc", 32'(fetch_exc), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("wrap1");
    chk("wrap1_pc", pc, 32'h0000_0000);
    chk("wrap1_fexc", 32'(fetch_exc), 32'd1);

    // reset overrides a pending redirect
    set_in(0, 1, 0, 0, 0, 1, 32'h0000_3444);
    tick("pend_rst");
    set_in(1, 0, 0, 0, 0, 1, 32'h0000_3888);
    tick("rst_mid");
    chk("rst_mid_pc", pc, 32'h0000_3000);
    chk("rst_mid_pend", 32'(redir_pending), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick("rst_mid_rel");
    chk("rst_mid_buf_gone", pc, 32'h0000_3000);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg, ep;
      tg = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                       : 32'h0000_3000 + (32'($urandom_range(0, 12'hFFF)) << 2);
      ep = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'h0000_3000 + 32'($urandom_range(0, 16'h3FFF));
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ep,
             $urandom_range(0, 3) == 0, tg);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
